// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: reads rs/rt, decodes control fields, scoreboards pending writes.
// Optional macro DECODE_WB_FORWARD_EN bypasses writeback data into the operands.
module decode_stage #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction_32,
    input  logic [31:0]       pc_32,
    output logic [ADDR_W-1:0] w_address_s1_5,
    output logic [ADDR_W-1:0] w_address_s2_5,
    input  logic [DATA_W-1:0] w_data_s1val_32,
    input  logic [DATA_W-1:0] w_data_s2val_32,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_address_5,
    input  logic [DATA_W-1:0] wb_data_32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc_32,
    output logic [5:0]        out_opcode_6,
    output logic [5:0]        out_funct_6,
    output logic [4:0]        out_shamt_5,
    output logic [DATA_W-1:0] out_rs_val_32,
    output logic [DATA_W-1:0] out_rt_val_32,
    output logic [31:0]       out_imm_32,
    output logic [ADDR_W-1:0] out_dest_5,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_illegal
);
    localparam int unsigned NumRegs = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0]       pc;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [31:0]       imm;
        logic [ADDR_W-1:0] dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              illegal;
    } id_ex_t;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [15:0]       imm16;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
    logic              zero_ext;
    logic              rs_used;
    logic              rt_used;
    logic              fwd_rs;
    logic              fwd_rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              stall;
    logic              accept;

    logic [NumRegs-1:0] pending_d, pending_q;
    logic               out_valid_d, out_valid_q;
    id_ex_t             id_ex_d, id_ex_q;

    assign opcode = instruction_32[31:26];
    assign funct  = instruction_32[5:0];
    assign rs     = instruction_32[25:21];
    assign rt     = instruction_32[20:16];
    assign rd     = instruction_32[15:11];
    assign imm16  = instruction_32[15:0];

    assign w_address_s1_5 = rs;
    assign w_address_s2_5 = rt;

    always_comb begin
        dest      = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        zero_ext  = 1'b0;
        rs_used   = 1'b1;
        rt_used   = 1'b0;
        case (opcode)
            6'h00: begin
                dest      = rd;
                reg_write = (funct != 6'h08);
                rt_used   = 1'b1;
            end
            6'h08, 6'h09, 6'h0A: begin
                dest      = rt;
                reg_write = 1'b1;
            end
            6'h0C, 6'h0D: begin
                dest      = rt;
                reg_write = 1'b1;
                zero_ext  = 1'b1;
            end
            6'h0F: begin
                dest      = rt;
                reg_write = 1'b1;
                rs_used   = 1'b0;
            end
            6'h23: begin
                dest      = rt;
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            6'h2B: begin
                mem_write = 1'b1;
                rt_used   = 1'b1;
            end
            6'h04, 6'h05: rt_used = 1'b1;
            6'h02:        rs_used = 1'b0;
            6'h03: begin
                dest      = '1;
                reg_write = 1'b1;
                rs_used   = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
        if (dest == '0) begin
            reg_write = 1'b0;
        end
    end

`ifdef DECODE_WB_FORWARD_EN
    assign fwd_rs = wb_en && (wb_address_5 == rs) && (rs != '0);
    assign fwd_rt = wb_en && (wb_address_5 == rt) && (rt != '0);
    assign rs_val = fwd_rs ? wb_data_32 : w_data_s1val_32;
    assign rt_val = fwd_rt ? wb_data_32 : w_data_s2val_32;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_32;
    assign fwd_rs = 1'b0;
    assign fwd_rt = 1'b0;
    assign rs_val = w_data_s1val_32;
    assign rt_val = w_data_s2val_32;
`endif

    // pending_q[0] is always 0, so $zero can never stall.
    assign stall = (rs_used && pending_q[rs] && !fwd_rs)
                || (rt_used && pending_q[rt] && !fwd_rt)
                || (reg_write && pending_q[dest]);

    assign in_ready = !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_address_5] = 1'b0;
        end
        if (accept && reg_write) begin
            pending_d[dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        id_ex_d     = id_ex_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d        = 1'b1;
            id_ex_d.pc         = pc_32;
            id_ex_d.opcode     = opcode;
            id_ex_d.funct      = funct;
            id_ex_d.shamt      = instruction_32[10:6];
            id_ex_d.rs_val     = rs_val;
            id_ex_d.rt_val     = rt_val;
            id_ex_d.imm        = zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
            id_ex_d.dest       = dest;
            id_ex_d.reg_write  = reg_write;
            id_ex_d.mem_read   = mem_read;
            id_ex_d.mem_write  = mem_write;
            id_ex_d.illegal    = illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            id_ex_q     <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            id_ex_q     <= id_ex_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc_32     = id_ex_q.pc;
    assign out_opcode_6  = id_ex_q.opcode;
    assign out_funct_6   = id_ex_q.funct;
    assign out_shamt_5   = id_ex_q.shamt;
    assign out_rs_val_32 = id_ex_q.rs_val;
    assign out_rt_val_32 = id_ex_q.rt_val;
    assign out_imm_32    = id_ex_q.imm;
    assign out_dest_5    = id_ex_q.dest;
    assign out_reg_write = id_ex_q.reg_write;
    assign out_mem_read  = id_ex_q.mem_read;
    assign out_mem_write = id_ex_q.mem_write;
    assign out_illegal   = id_ex_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode / operand-fetch stage that sits directly upstream of `register_file`. It drives the register file's two read addresses, captures the returned operands, and decodes the MIPS instruction into control fields. The result goes into an ID/EX pipeline register with a valid/ready handshake. A per-register pending-write scoreboard stalls issue on RAW and WAW hazards until the writeback stage retires the producing instruction.

## Interface
Parameters:
- `ADDR_W`, 5: register address width (32 registers).
- `DATA_W`, 32: datapath width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts instruction this cycle.
- `instruction_32`  in  32  instruction word.
- `pc_32`  in  32  PC of the instruction.
- `w_address_s1_5`  out  5  register-file read address, rs = instr[25:21], combinational.
- `w_address_s2_5`  out  5  register-file read address, rt = instr[20:16], combinational.
- `w_data_s1val_32`  in  32  rs value from register file.
- `w_data_s2val_32`  in  32  rt value from register file.
- `wb_en`  in  1  writeback retires a register write; same signal as register-file `w_en`.
- `wb_address_5`  in  5  writeback destination.
- `wb_data_32`  in  32  writeback data.
- `out_valid`  out  1  ID/EX register holds a valid instruction.
- `out_ready`  in  1  execute stage consumes the ID/EX register.
- `out_pc_32`  out  32  latched PC.
- `out_opcode_6`  out  6  instr[31:26].
- `out_funct_6`  out  6  instr[5:0].
- `out_shamt_5`  out  5  instr[10:6].
- `out_rs_val_32`  out  32  latched rs operand.
- `out_rt_val_32`  out  32  latched rt operand.
- `out_imm_32`  out  32  extended immediate.
- `out_dest_5`  out  5  destination register.
- `out_reg_write`  out  1  instruction writes `out_dest_5`.
- `out_mem_read`  out  1  load.
- `out_mem_write`  out  1  store.
- `out_illegal`  out  1  unrecognised opcode.

## Operation
- **Decode.**
  - opcode 0x00 (R-type): dest = rd; reg_write = 1, except funct 0x08 (jr), which has reg_write = 0.
  - 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0F, 0x23: dest = rt, reg_write = 1. 0x23 also sets mem_read.
  - 0x2B: mem_write; no register write.
  - 0x04, 0x05, 0x02: no register write.
  - 0x03 (jal): dest = 31, reg_write = 1.
  - Any other opcode: out_illegal = 1; all write/mem controls 0.
  - reg_write is forced to 0 when dest = 0.
- **Immediate.** Zero-extended for 0x0C and 0x0D; sign-extended otherwise.
- **Source usage.**
  - rs is used by every opcode except 0x02, 0x03 and 0x0F.
  - rt is used by R-type, 0x2B, 0x04 and 0x05.
  - Register 0 is never a hazard.
- **Scoreboard.** 32 `pending` bits; bit 0 is hardwired to 0.
  - Set for dest on accept when reg_write = 1.
  - Cleared for `wb_address_5` when `wb_en` = 1.
  - Set and clear to the same register in the same cycle: set wins.
- **Stall.** Asserted when a used source is pending, or when the dest is already pending (WAW).
- **Readiness.** `in_ready` = !stall && (!out_valid || out_ready).
- **Accept.** Accept = in_valid && in_ready. On accept, all out_* fields load and out_valid is set.
- **Drain.** If out_ready is high and there is no accept, out_valid clears.

## Timing
- **Latency.** One cycle: an instruction accepted at edge N appears with out_valid high after edge N.
- **Reset.** All outputs registered; all are 0 after reset. `pending` = 0.
- **Output hold.** While out_valid && !out_ready, every out_* field holds stable.
- **Operand read without bypass.** A stalled source is re-read from the register file the cycle after its pending bit clears.
- **Reset mid-operation.** Reset discards the ID/EX contents and the scoreboard. An in-flight writeback arriving after reset still writes the register file, but is ignored by the scoreboard.

## Configuration
- **`DECODE_WB_FORWARD_EN` defined.** A source matching `wb_address_5` while `wb_en` = 1 (source ≠ 0) is not a hazard. Its operand is taken from `wb_data_32` instead of the register file. Bypassing removes one stall cycle per RAW.
- **`DECODE_WB_FORWARD_EN` undefined.** No bypass: RAW stalls through the writeback cycle, and the operand is read from the register file one cycle later.

## Test plan
- **Reset.** Assert reset 2 cycles with in_valid = 1 → out_valid = 0, all outputs 0, in_ready = 1 after release.
- **Decode addi.** Issue `addi $5,$3,-4` (0x2065FFFC) with rf returning 3 → out_dest_5 = 5, out_imm_32 = 0xFFFFFFFC, out_rs_val_32 = 3, out_reg_write = 1; `ori` with imm 0xFFFF gives out_imm_32 = 0x0000FFFF.
- **RAW hazard.** Issue `add $4,$1,$2` then `sub $6,$4,$1`; writeback of $4 = 0x33 at cycle W.
  - Without the macro: in_ready low until W+1, and out_rs_val_32 = 0x33.
  - With `DECODE_WB_FORWARD_EN`: accepted at W with out_rs_val_32 = 0x33.
- **Backpressure.** Hold out_ready = 0 for 3 cycles with out_valid = 1 → outputs stable, in_ready = 0; raising out_ready drains and accepts the next instruction in the same cycle.
- **$zero and illegal.** `add $0,$1,$2` → out_reg_write = 0, no scoreboard bit set; opcode 0x3F → out_illegal = 1.
- **Set/clear collision.** wb_en to $7 in the same cycle as accepting `lw $7,0($1)` → pending[7] = 1 afterwards, and a following `add $8,$7,$7` stalls.
